// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: next-PC mode codes, default vectors and
// the pending-redirect FSM encoding used by pc_sequencer.
// Contents: NPC_* mode constants, *_VECTOR_DEF defaults, pend_state_e.
package mips_pkg;

    // redirect_mode encodings
    localparam logic [1:0] NPC_BRANCH = 2'b00;
    localparam logic [1:0] NPC_JUMP   = 2'b01;
    localparam logic [1:0] NPC_JR     = 2'b10;
    localparam logic [1:0] NPC_ERET   = 2'b11;

    // Default fetch vectors
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_4180;

    // Pending-redirect FSM
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } pend_state_e;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational redirect target, effectiveness and alignment check.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the target is consumed.
// Ports: i_valid/i_mode/i_br_taken qualify the redirect; i_pc4, i_imm26,
//        i_reg_addr, i_epc are the target operands; o_eff, o_target and
//        o_misaligned (already qualified by o_eff) are the results.
module npc_target_calc
    import mips_pkg::*;
(
    input  logic        i_valid,
    input  logic [1:0]  i_mode,
    input  logic        i_br_taken,
    input  logic [31:0] i_pc4,
    input  logic [25:0] i_imm26,
    input  logic [31:0] i_reg_addr,
    input  logic [31:0] i_epc,
    output logic        o_eff,
    output logic [31:0] o_target,
    output logic        o_misaligned
);

    logic [31:0] w_br_off;

    // Sign-extended word offset of the branch immediate
    assign w_br_off = {{14{i_imm26[15]}}, i_imm26[15:0], 2'b00};

    always_comb begin
        o_target = i_pc4 + 32'd4;
        unique case (i_mode)
            NPC_BRANCH: o_target = i_pc4 + w_br_off;
            NPC_JUMP:   o_target = {i_pc4[31:28], i_imm26, 2'b00};
            NPC_JR:     o_target = i_reg_addr;
            NPC_ERET:   o_target = i_epc;
            default:    o_target = i_pc4 + 32'd4;
        endcase
    end

    // An untaken branch is not a redirect at all
    assign o_eff        = i_valid && !((i_mode == NPC_BRANCH) && !i_br_taken);
    assign o_misaligned = o_eff && (o_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with stall hold, pending-redirect buffer and misaligned
// target trap. Latency: redirect/exception lands in pc on the next edge.
// Backpressure: stall holds pc; redirects seen under stall are buffered.
// Ports: clk/reset (sync, active-high); stall; redirect_* / imm26 / reg_addr /
//        br_taken / epc_in describe the resolved redirect; exc_req; outputs
//        pc, pc_plus4, addr_err (1-cycle pulse), redirect_pend.
// Optional: define PC_SEQ_PERF_CNT_EN to add CNT_W-wide saturating
//        redirect_cnt / stall_cnt outputs.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    parameter int          CNT_W        = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [1:0]       redirect_mode,
    input  logic [31:0]      redirect_pc4,
    input  logic [25:0]      imm26,
    input  logic [31:0]      reg_addr,
    input  logic             br_taken,
    input  logic [31:0]      epc_in,
    input  logic             exc_req,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             addr_err,
    output logic             redirect_pend
`ifdef PC_SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    pend_state_e r_state;
    pend_state_e w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic        r_addr_err;

    logic        w_eff;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic        w_exc;
    logic [31:0] w_pc_nxt;
    logic        w_buf_load;
    logic        w_pc_redir;

    npc_target_calc u_calc (
        .i_valid      (redirect_valid),
        .i_mode       (redirect_mode),
        .i_br_taken   (br_taken),
        .i_pc4        (redirect_pc4),
        .i_imm26      (imm26),
        .i_reg_addr   (reg_addr),
        .i_epc        (epc_in),
        .o_eff        (w_eff),
        .o_target     (w_target),
        .o_misaligned (w_misaligned)
    );

    // A misaligned redirect is turned into an exception redirect
    assign w_exc = exc_req || w_misaligned;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_buf_load  = 1'b0;
        w_pc_redir  = 1'b0;
        if (w_exc) begin
            // Exceptions ignore stall and discard any buffered redirect
            w_pc_nxt    = EXC_VECTOR;
            w_state_nxt = ST_IDLE;
            w_pc_redir  = 1'b1;
        end else if (!stall) begin
            w_state_nxt = ST_IDLE;
            if (w_eff) begin
                // A fresh redirect is younger than anything buffered
                w_pc_nxt   = w_target;
                w_pc_redir = 1'b1;
            end else if (r_state == ST_PEND) begin
                w_pc_nxt   = r_buf;
                w_pc_redir = 1'b1;
            end else begin
                w_pc_nxt = r_pc + 32'd4;
            end
        end else if (w_eff) begin
            // Stalled: hold pc, buffer the youngest redirect
            w_buf_load  = 1'b1;
            w_state_nxt = ST_PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_VECTOR;
            r_buf      <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_addr_err <= w_misaligned;
            if (w_buf_load) begin
                r_buf <= w_target;
            end
        end
    end

    assign pc            = r_pc;
    assign pc_plus4      = r_pc + 32'd4;
    assign addr_err      = r_addr_err;
    assign redirect_pend = (r_state == ST_PEND);

`ifdef PC_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] r_redirect_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_pc_redir && (r_redirect_cnt != {CNT_W{1'b1}})) begin
                r_redirect_cnt <= r_redirect_cnt + 1'b1;
            end
            if (stall && !w_exc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign stall_cnt    = r_stall_cnt;
`else
    // w_pc_redir only feeds the performance counters
    logic w_unused;
    assign w_unused = w_pc_redir;
`endif

endmodule
